// File: rtl/test2_en_reg.sv
// Enable register: WIDTH-bit D flop that loads D_IN when EN is high, holds otherwise.
// Latency: one CLK rising edge from D_IN/EN to D_OUT; synchronous active-low reset has priority over EN.
// Backpressure: none; EN is the only qualifier. Optional macro TEST2_CLOCK_GATING_EN swaps the feedback mux for a latch-based clock gate.
module test2_en_reg #(
  parameter int          WIDTH       = 8,
  parameter logic [63:0] RESET_VALUE = 64'h0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             EN,
  output logic [WIDTH-1:0] D_OUT
);

  // Reset value cut down to the register width.
  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] data_q;

`ifdef TEST2_CLOCK_GATING_EN

  // Gate enable; reset forces the gate open so the reset value can be loaded.
  logic gate_en;
  logic gate_q;
  logic gclk;

  assign gate_en = EN | ~RST_N;

  // Latch is transparent while CLK is low, so enable changes during the high phase cannot chop the pulse.
  always_latch begin
    if (!CLK) begin
      gate_q <= gate_en;
    end
  end

  assign gclk = CLK & gate_q;

  // Data flops load unconditionally on every gated-clock edge.
  always_ff @(posedge gclk) begin
    if (!RST_N) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= D_IN;
    end
  end

`else

  // Free-running clock with a feedback mux holding the value when EN is low.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= EN ? D_IN : data_q;
    end
  end

`endif

  // Output comes straight from the flops: no combinational path from D_IN or EN.
  assign D_OUT = data_q;

endmodule

// File: tb/tb_test2_en_reg.sv
// Self-checking bench for test2_en_reg: directed scenarios plus randomized load/hold/reset traffic.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
// A reference value is tracked per edge from the register's rules (reset -> 0, enable -> load, else hold).
module tb_test2_en_reg;

  localparam int W = 8;
  localparam logic [W-1:0] RST_EXP = 8'h00;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         EN;
  logic [W-1:0] D_IN;
  logic [W-1:0] D_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference register contents as implied by the behavioural rules.
  logic [W-1:0] model;

  always #5 CLK = ~CLK;

  test2_en_reg #(
    .WIDTH       (W),
    .RESET_VALUE (64'h0)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D_IN  (D_IN),
    .EN    (EN),
    .D_OUT (D_OUT)
  );

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one set of inputs for one rising edge, update the reference, then compare.
  task automatic cycle(input logic rst_n, input logic en, input logic [W-1:0] din, input string tag);
    @(negedge CLK);
    RST_N = rst_n;
    EN    = en;
    D_IN  = din;
    @(posedge CLK);
    if (!rst_n)  model = RST_EXP;
    else if (en) model = din;
    #1;
    check_val(tag, D_OUT, model);
  endtask

  initial begin
    logic         r_rst;
    logic         r_en;
    logic [W-1:0] r_din;
    logic [W-1:0] held;

    RST_N = 1'b1;
    EN    = 1'b0;
    D_IN  = '0;
    model = 'x;

    // Reset with enable high and live data: reset must win.
    cycle(1'b0, 1'b1, 8'hAA, "reset_edge1");
    cycle(1'b0, 1'b1, 8'hAA, "reset_edge2");
    check_val("reset_value", D_OUT, 8'h00);

    // Load/hold sequence.
    cycle(1'b1, 1'b1, 8'h01, "load_1");
    cycle(1'b1, 1'b0, 8'h00, "hold_in0");
    cycle(1'b1, 1'b0, 8'h01, "hold_in1");
    cycle(1'b1, 1'b1, 8'h00, "load_0");

    // Hold against a changing input, then repeated load of the same value.
    cycle(1'b1, 1'b1, 8'h03, "load_3");
    cycle(1'b1, 1'b0, 8'h0D, "hold_3");
    cycle(1'b1, 1'b1, 8'h0D, "load_13_a");
    cycle(1'b1, 1'b1, 8'h0D, "load_13_b");

    // Full width, MSB preserved.
    cycle(1'b1, 1'b1, 8'hFE, "full_fe");
    cycle(1'b1, 1'b1, 8'hFF, "full_ff");

    // Reset in the middle of traffic, then resume.
    cycle(1'b1, 1'b1, 8'h55, "load_55");
    cycle(1'b0, 1'b1, 8'h77, "mid_reset");
    cycle(1'b1, 1'b1, 8'h77, "after_reset");

    // Enable glitch during the high phase with EN low at the edge.
    cycle(1'b1, 1'b1, 8'h5A, "load_5a");
    cycle(1'b1, 1'b0, 8'h5A, "hold_5a");
    held = model;
    EN   = 1'b1;
    D_IN = 8'hC3;
    #1;
    EN   = 1'b0;
    #1;
    check_val("glitch_no_comb", D_OUT, held);
    @(posedge CLK);
    #1;
    check_val("glitch_edge", D_OUT, held);

    // Reset pulse between edges has no asynchronous effect.
    RST_N = 1'b0;
    #2;
    check_val("rst_no_async", D_OUT, held);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_val("rst_pulse_edge", D_OUT, held);

    // Data changes between edges while enabled only take effect at the edge.
    @(negedge CLK);
    EN   = 1'b1;
    D_IN = 8'h3C;
    #1;
    check_val("no_comb_path", D_OUT, held);
    @(posedge CLK);
    model = 8'h3C;
    #1;
    check_val("load_3c", D_OUT, model);

    // Randomized load/hold/reset traffic.
    for (int i = 0; i < 300; i++) begin
      r_rst = ($urandom_range(0, 15) != 0);
      r_en  = $urandom_range(0, 1);
      r_din = W'($urandom);
      cycle(r_rst, r_en, r_din, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
